// File: rtl/clock_pkg.sv
// Shared digit type, BCD limits and preset validation for the mm:ss counter.
package clock_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX      = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;

  // True when both digits are decimal and the pair does not exceed max.
  function automatic logic bcd_pair_valid(input bcd_t tens, input bcd_t units,
                                          input int unsigned max);
    int unsigned value;
    value = 32'(tens) * 32'd10 + 32'(units);
    return (tens <= BCD_MAX) && (units <= BCD_MAX) && (value <= max);
  endfunction

endpackage

// File: rtl/bcd_digit_pair.sv
// Two-digit BCD up/down counter with range 00..MAX_VAL.
// term_o flags the value a step leaves from when it wraps: MAX_VAL when
// counting up, 00 when counting down. It is used by the parent both as the
// carry/borrow into the next pair and as the terminal-count indicator.
module bcd_digit_pair
  import clock_pkg::*;
#(
  parameter int unsigned MAX_VAL = 59
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       step_i,
  input  logic       up_i,
  input  logic       load_i,
  input  logic [3:0] load_tens_i,
  input  logic [3:0] load_units_i,
  output logic [3:0] tens_o,
  output logic [3:0] units_o,
  output logic       term_o
);

  localparam bcd_t MAX_TENS  = bcd_t'(MAX_VAL / 10);
  localparam bcd_t MAX_UNITS = bcd_t'(MAX_VAL % 10);

  bcd_t tens_q, tens_d;
  bcd_t units_q, units_d;
  logic term;

  // Next-value logic: load wins over step; a step from the terminal value wraps.
  always_comb begin
    term    = up_i ? ((tens_q == MAX_TENS) && (units_q == MAX_UNITS))
                   : ((tens_q == 4'd0) && (units_q == 4'd0));
    tens_d  = tens_q;
    units_d = units_q;
    if (load_i) begin
      tens_d  = load_tens_i;
      units_d = load_units_i;
    end else if (step_i) begin
      if (up_i) begin
        if (term) begin
          tens_d  = 4'd0;
          units_d = 4'd0;
        end else if (units_q == BCD_MAX) begin
          tens_d  = tens_q + 4'd1;
          units_d = 4'd0;
        end else begin
          units_d = units_q + 4'd1;
        end
      end else begin
        if (term) begin
          tens_d  = MAX_TENS;
          units_d = MAX_UNITS;
        end else if (units_q == 4'd0) begin
          tens_d  = tens_q - 4'd1;
          units_d = BCD_MAX;
        end else begin
          units_d = units_q - 4'd1;
        end
      end
    end
  end

  // Digit registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tens_q  <= 4'd0;
      units_q <= 4'd0;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign tens_o  = tens_q;
  assign units_o = units_q;
  assign term_o  = term;

endmodule

// File: rtl/bcd_mmss_counter.sv
// Minutes:seconds BCD counter with internal prescaler, up/down counting,
// validated preset load, wrap or saturate at terminal count, and a square-wave
// LED running at the count rate.
module bcd_mmss_counter
  import clock_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned TICK_HZ     = 1,
  parameter int unsigned MIN_MAX     = 59,
  parameter bit          WRAP_EN     = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        up_i,
  input  logic        load_i,
  input  logic [15:0] load_value_i,
  output logic        tick_o,
  output logic        led_one_second_o,
  output logic [3:0]  sec_unit_o,
  output logic [3:0]  sec_dec_o,
  output logic [3:0]  min_unit_o,
  output logic [3:0]  min_dec_o,
  output logic        tc_o,
  output logic        load_err_o
);

  localparam int unsigned DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(DIV / 2 - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          tc_q, tc_d;
  logic          err_q, err_d;
  logic          led_q, led_d;

  bcd_t ld_min_dec, ld_min_unit, ld_sec_dec, ld_sec_unit;
  logic load_valid, load_ok, load_bad;
  logic tick_evt, half_evt, at_term, step, min_step;
  logic sec_term, min_term;

  assign ld_min_dec  = load_value_i[15:12];
  assign ld_min_unit = load_value_i[11:8];
  assign ld_sec_dec  = load_value_i[7:4];
  assign ld_sec_unit = load_value_i[3:0];

  // Control decode: load beats a coincident tick; saturate mode drops the
  // digit step at terminal but still reports the tick and terminal count.
  always_comb begin
    load_valid = bcd_pair_valid(ld_min_dec, ld_min_unit, MIN_MAX)
              && bcd_pair_valid(ld_sec_dec, ld_sec_unit, 59)
              && (ld_sec_dec <= SEC_TENS_MAX);
    load_ok    = load_i && load_valid;
    load_bad   = load_i && !load_valid;
    tick_evt   = en_i && (presc_q == PRESC_LAST);
    half_evt   = en_i && (presc_q == PRESC_HALF);
    at_term    = sec_term && min_term;
    tick_d     = tick_evt && !load_i;
    tc_d       = tick_d && at_term;
    err_d      = load_bad;
    step       = tick_d && !(at_term && !WRAP_EN);
    min_step   = step && sec_term;
    led_d      = led_q ^ ((tick_evt || half_evt) && !load_i);

    presc_d = presc_q;
    if (load_ok) begin
      presc_d = '0;
    end else if (load_bad) begin
      presc_d = presc_q;
    end else if (tick_evt) begin
      presc_d = '0;
    end else if (en_i) begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Prescaler, LED and status-pulse registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      tc_q    <= 1'b0;
      err_q   <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      tc_q    <= tc_d;
      err_q   <= err_d;
      led_q   <= led_d;
    end
  end

  bcd_digit_pair #(.MAX_VAL(59)) u_sec (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .step_i       (step),
    .up_i         (up_i),
    .load_i       (load_ok),
    .load_tens_i  (ld_sec_dec),
    .load_units_i (ld_sec_unit),
    .tens_o       (sec_dec_o),
    .units_o      (sec_unit_o),
    .term_o       (sec_term)
  );

  bcd_digit_pair #(.MAX_VAL(MIN_MAX)) u_min (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .step_i       (min_step),
    .up_i         (up_i),
    .load_i       (load_ok),
    .load_tens_i  (ld_min_dec),
    .load_units_i (ld_min_unit),
    .tens_o       (min_dec_o),
    .units_o      (min_unit_o),
    .term_o       (min_term)
  );

  assign tick_o           = tick_q;
  assign tc_o             = tc_q;
  assign load_err_o       = err_q;
  assign led_one_second_o = led_q;

endmodule

// File: tb/tb_bcd_mmss_counter.sv
// Directed bench for bcd_mmss_counter. Three instances share the stimulus:
// [0] MIN_MAX=59 wrap, [1] MIN_MAX=59 saturate, [2] MIN_MAX=99 wrap; all DIV=10.
module tb_bcd_mmss_counter;

  logic        clk;
  logic        rst;
  logic        en;
  logic        up;
  logic        load;
  logic [15:0] load_val;

  logic       tick [3];
  logic       led  [3];
  logic       tc   [3];
  logic       err  [3];
  logic [3:0] su   [3];
  logic [3:0] sd   [3];
  logic [3:0] mu   [3];
  logic [3:0] md   [3];

  int checks   = 0;
  int failures = 0;

  bcd_mmss_counter #(.CLK_FREQ_HZ(10), .TICK_HZ(1), .MIN_MAX(59), .WRAP_EN(1'b1)) u_wrap59 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .load_i(load), .load_value_i(load_val),
    .tick_o(tick[0]), .led_one_second_o(led[0]), .sec_unit_o(su[0]), .sec_dec_o(sd[0]),
    .min_unit_o(mu[0]), .min_dec_o(md[0]), .tc_o(tc[0]), .load_err_o(err[0]));

  bcd_mmss_counter #(.CLK_FREQ_HZ(10), .TICK_HZ(1), .MIN_MAX(59), .WRAP_EN(1'b0)) u_sat59 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .load_i(load), .load_value_i(load_val),
    .tick_o(tick[1]), .led_one_second_o(led[1]), .sec_unit_o(su[1]), .sec_dec_o(sd[1]),
    .min_unit_o(mu[1]), .min_dec_o(md[1]), .tc_o(tc[1]), .load_err_o(err[1]));

  bcd_mmss_counter #(.CLK_FREQ_HZ(10), .TICK_HZ(1), .MIN_MAX(99), .WRAP_EN(1'b1)) u_wrap99 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .load_i(load), .load_value_i(load_val),
    .tick_o(tick[2]), .led_one_second_o(led[2]), .sec_unit_o(su[2]), .sec_dec_o(sd[2]),
    .min_unit_o(mu[2]), .min_dec_o(md[2]), .tc_o(tc[2]), .load_err_o(err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] val;
    logic        err59;
    logic [15:0] dig59;
    logic        err99;
    logic [15:0] dig99;
  } load_vec_t;

  load_vec_t lv [8];

  function automatic logic [15:0] dig(input int k);
    return {md[k], mu[k], sd[k], su[k]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Runs n edges and expects the first tick exactly on the last one.
  task automatic wait_tick(input int n, input string name);
    int early;
    early = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (i < n && tick[0]) early++;
    end
    check($sformatf("%s early_ticks", name), early, 0);
    check($sformatf("%s tick", name), {tick[0], tick[1], tick[2]}, 3'b111);
  endtask

  task automatic do_load(input logic [15:0] v);
    load     = 1'b1;
    load_val = v;
    cyc(1);
    load     = 1'b0;
  endtask

  initial begin
    int ticks, last_tick, led_high, led_tog, tc_cnt, changes;
    logic led_prev;
    logic [15:0] dig_hold;

    lv[0] = '{16'h1234, 1'b0, 16'h1234, 1'b0, 16'h1234};
    lv[1] = '{16'h0A00, 1'b1, 16'h1234, 1'b1, 16'h1234};
    lv[2] = '{16'h0060, 1'b1, 16'h1234, 1'b1, 16'h1234};
    lv[3] = '{16'h6000, 1'b1, 16'h1234, 1'b0, 16'h6000};
    lv[4] = '{16'h9959, 1'b1, 16'h1234, 1'b0, 16'h9959};
    lv[5] = '{16'h005A, 1'b1, 16'h1234, 1'b1, 16'h9959};
    lv[6] = '{16'h5959, 1'b0, 16'h5959, 1'b0, 16'h5959};
    lv[7] = '{16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};

    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 16'h0000;
    #2 rst = 1'b0;
    #10;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset digits[%0d]", k), dig(k), 16'h0000);
      check($sformatf("reset flags[%0d]", k), {tick[k], tc[k], err[k], led[k]}, 4'b0000);
    end
    @(negedge clk);
    rst = 1'b1;

    // Free-running count for 100 clocks.
    en = 1'b1;
    up = 1'b1;
    ticks = 0; last_tick = 0; led_high = 0; led_tog = 0; tc_cnt = 0;
    led_prev = led[0];
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (tick[0]) begin
        ticks++;
        check("tick spacing", i - last_tick, 10);
        last_tick = i;
      end
      if (led[0]) led_high++;
      if (led[0] != led_prev) led_tog++;
      if (tc[0]) tc_cnt++;
      led_prev = led[0];
    end
    en = 1'b0;
    check("run100 ticks", ticks, 10);
    check("run100 led_high", led_high, 50);
    check("run100 led_toggles", led_tog, 20);
    check("run100 tc", tc_cnt, 0);
    for (int k = 0; k < 3; k++)
      check($sformatf("run100 digits[%0d]", k), dig(k), 16'h0010);

    // Load validation table, prescaler frozen.
    for (int v = 0; v < 8; v++) begin
      load = 1'b1;
      load_val = lv[v].val;
      cyc(1);
      load = 1'b0;
      check($sformatf("load%0d dig59", v), dig(0), lv[v].dig59);
      check($sformatf("load%0d dig59sat", v), dig(1), lv[v].dig59);
      check($sformatf("load%0d err59", v), err[0], lv[v].err59);
      check($sformatf("load%0d dig99", v), dig(2), lv[v].dig99);
      check($sformatf("load%0d err99", v), err[2], lv[v].err99);
      check($sformatf("load%0d no_tick", v), tick[0], 1'b0);
      cyc(1);
      check($sformatf("load%0d err_pulse", v), {err[0], err[2]}, 2'b00);
    end

    // Up-count through terminal.
    do_load(16'h5958);
    en = 1'b1;
    wait_tick(10, "up1");
    check("up1 dig59", dig(0), 16'h5959);
    check("up1 dig99", dig(2), 16'h5959);
    check("up1 tc", {tc[0], tc[1], tc[2]}, 3'b000);
    wait_tick(10, "up2");
    check("up2 wrap dig", dig(0), 16'h0000);
    check("up2 sat dig", dig(1), 16'h5959);
    check("up2 dig99", dig(2), 16'h6000);
    check("up2 tc", {tc[0], tc[1], tc[2]}, 3'b110);
    wait_tick(10, "up3");
    check("up3 wrap dig", dig(0), 16'h0001);
    check("up3 sat dig", dig(1), 16'h5959);
    check("up3 dig99", dig(2), 16'h6001);
    check("up3 tc", {tc[0], tc[1], tc[2]}, 3'b010);

    // Down-count borrow and wrap.
    up = 1'b0;
    do_load(16'h0100);
    wait_tick(10, "dn1");
    for (int k = 0; k < 3; k++)
      check($sformatf("dn1 digits[%0d]", k), dig(k), 16'h0059);
    do_load(16'h0000);
    wait_tick(10, "dn2");
    check("dn2 wrap dig", dig(0), 16'h5959);
    check("dn2 sat dig", dig(1), 16'h0000);
    check("dn2 dig99", dig(2), 16'h9959);
    check("dn2 tc", {tc[0], tc[1], tc[2]}, 3'b111);

    // Load coincident with a tick edge.
    cyc(9);
    load = 1'b1;
    load_val = 16'h1234;
    cyc(1);
    load = 1'b0;
    check("loadtick dig", dig(0), 16'h1234);
    check("loadtick tick_tc", {tick[0], tc[0], err[0]}, 3'b000);
    wait_tick(10, "loadtick restart");
    check("loadtick after dig", dig(0), 16'h1233);

    // Enable freeze mid-period with a direction change while frozen.
    cyc(6);
    en = 1'b0;
    up = 1'b1;
    led_prev = led[0];
    dig_hold = dig(0);
    changes = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (led[0] != led_prev || dig(0) != dig_hold || tick[0]) changes++;
    end
    check("freeze changes", changes, 0);
    en = 1'b1;
    wait_tick(4, "resume");
    check("resume dig", dig(0), 16'h1234);
    cyc(5);
    check("dirchg mid dig", dig(0), 16'h1234);
    up = 1'b0;
    wait_tick(5, "dirchg");
    check("dirchg dig", dig(0), 16'h1233);

    // Asynchronous reset between edges.
    cyc(3);
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("areset digits[%0d]", k), dig(k), 16'h0000);
      check($sformatf("areset flags[%0d]", k), {tick[k], tc[k], err[k], led[k]}, 4'b0000);
    end
    @(negedge clk);
    rst = 1'b1;

    // MIN_MAX=99 wrap from 99:59.
    up = 1'b1;
    do_load(16'h9959);
    check("load9959 dig99", dig(2), 16'h9959);
    check("load9959 err59", {err[0], err[2]}, 2'b10);
    wait_tick(10, "wrap99");
    check("wrap99 dig", dig(2), 16'h0000);
    check("wrap99 tc", tc[2], 1'b1);
    check("wrap99 dig59", dig(0), 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
